bus_req_ctrl: RTL
=================

BUS_REQ_CTRL -- requirements
Module: bus_req_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the maximum wait cycles per handshake phase before error (legal range 2..255).
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the completed-transaction counter.
REQ-003 ck  in  1  SHALL be the rising-edge clock.
REQ-004 arst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 isolateM1M3  in  1  SHALL indicate that the downstream consumer is isolated, with data_tx clamped to 0.
REQ-006 start  in  1  SHALL be a single-cycle request to begin one four-phase transaction.
REQ-007 clear_err  in  1  SHALL be a single-cycle request to leave the error state.
REQ-008 data_ready  out  1  SHALL be the request toward the consumer, which registers it back as data_tx.
REQ-009 data_tx  in  1  SHALL be the consumer's registered echo of data_ready (one-cycle latency).
REQ-010 busy  out  1  SHALL be high in any state other than IDLE.
REQ-011 done  out  1  SHALL be a one-cycle pulse on successful transaction completion.
REQ-012 timeout_err  out  1  SHALL be a sticky flag for a handshake timeout.
REQ-013 iso_abort  out  1  SHALL be a sticky flag for a transaction aborted by isolation.
REQ-014 txn_count  out  CNT_W  SHALL count completed transactions.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, REQ_HI, REQ_LO, ERR.
REQ-016 In IDLE, start=1 with isolateM1M3=0 SHALL move to REQ_HI and clear the wait counter; start is ignored while isolateM1M3=1.
REQ-017 In REQ_HI, data_ready SHALL be registered high, first visible the cycle after the state is entered.
REQ-018 In REQ_HI, data_tx=1 SHALL move to REQ_LO with data_ready low the next cycle.
REQ-019 In REQ_LO, data_tx=0 SHALL return to IDLE, pulse done for one cycle and increment txn_count.
REQ-020 txn_count SHALL wrap modulo 2^CNT_W without saturating.
REQ-021 A wait counter SHALL increment each cycle spent in REQ_HI or REQ_LO and SHALL clear on every phase transition.
REQ-022 When the wait counter reaches TIMEOUT_CYCLES without the awaited data_tx level, the FSM SHALL enter ERR, drive data_ready=0 and set timeout_err.
REQ-023 In ERR, only clear_err=1 SHALL return the FSM to IDLE and clear timeout_err; start is ignored.
REQ-024 isolateM1M3=1 in REQ_HI or REQ_LO SHALL force IDLE on the next edge, set iso_abort, drive data_ready=0, with no done pulse and no count increment; this takes priority over the data_tx and timeout checks in the same cycle.
REQ-025 iso_abort SHALL clear on the first start that is accepted.
REQ-026 start asserted while busy=1 SHALL be ignored without queuing.
REQ-027 If clear_err and start are both high in ERR, the FSM SHALL go to IDLE only, and start SHALL be dropped.
REQ-028 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-029 arst=1 SHALL, asynchronously: force state IDLE; drive data_ready, busy, done, timeout_err and iso_abort to 0; and clear txn_count and the wait counter to 0.
REQ-030 Reset asserted mid-transaction SHALL abort the transaction without a done pulse; the first accepted start after reset release begins from IDLE.

Structure
REQ-031 The state enum and the default TIMEOUT_CYCLES constant SHALL reside in the shared package mybus_pkg.
REQ-032 The block SHALL be one module, with an optional sub-module bus_wait_timer for the wait counter and timeout compare.

Verification
REQ-033 Reset, then start with data_tx echoing data_ready one cycle late -> data_ready high for 2 cycles, done pulses once, txn_count=1, busy low afterwards.
REQ-034 Start with data_tx held at 0 and TIMEOUT_CYCLES=16 -> ERR entered after 16 cycles in REQ_HI, timeout_err=1, data_ready=0; clear_err -> IDLE with timeout_err=0.
REQ-035 Start, then isolateM1M3=1 on the second cycle of REQ_HI -> IDLE next edge, iso_abort=1, txn_count unchanged, no done; start while isolated -> ignored.
REQ-036 Run 256 back-to-back transactions with CNT_W=8 -> txn_count wraps to 0, done pulses 256 times.
REQ-037 Assert arst in REQ_LO -> all outputs 0 immediately; after release, a start completes normally with txn_count=1.
REQ-038 Pulse start during REQ_HI -> no second transaction; exactly one done pulse.

Source files
------------

// File: rtl/mybus_pkg.sv
// Shared definitions for the four-phase bus request controller:
// FSM state encoding, default timeout and wait-counter width.
package mybus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2,
    ERR    = 2'd3
  } state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;
  // Wide enough for the largest legal timeout (255).
  localparam int unsigned WAIT_W = 8;

endpackage

// File: rtl/bus_wait_timer.sv
// Per-phase wait counter; flags the cycle in which the current phase
// has used up its TIMEOUT_CYCLES budget.
module bus_wait_timer
  import mybus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic ck,
  input  logic arst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LAST_CNT = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;

  // Next wait count: clear on phase change, otherwise advance while waiting.
  always_comb begin
    wait_d = wait_q;
    if (clr) begin
      wait_d = '0;
    end else if (en) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = wait_q;
    end
  end

  // Wait count register.
  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  // The counter would reach TIMEOUT_CYCLES on this edge.
  assign expired = (wait_q == LAST_CNT);

endmodule

// File: rtl/bus_req_ctrl.sv
// Four-phase request/acknowledge controller toward an isolatable consumer,
// with timeout error handling and a wrapping completed-transaction counter.
module bus_req_ctrl
  import mybus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             ck,
  input  logic             arst,
  input  logic             isolateM1M3,
  input  logic             start,
  input  logic             clear_err,
  output logic             data_ready,
  input  logic             data_tx,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic             iso_abort,
  output logic [CNT_W-1:0] txn_count
);

  state_e             state_q, state_d;
  logic               data_ready_q, data_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timeout_err_q, timeout_err_d;
  logic               iso_abort_q, iso_abort_d;
  logic [CNT_W-1:0]   txn_count_q, txn_count_d;
  logic               wait_clr, wait_en, expired;

  bus_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .ck     (ck),
    .arst   (arst),
    .clr    (wait_clr),
    .en     (wait_en),
    .expired(expired)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_d       = state_q;
    timeout_err_d = timeout_err_q;
    iso_abort_d   = iso_abort_q;
    done_d        = 1'b0;
    txn_count_d   = txn_count_q;
    case (state_q)
      IDLE: begin
        if (start && !isolateM1M3) begin
          state_d     = REQ_HI;
          iso_abort_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      REQ_HI: begin
        // Isolation outranks both the handshake and the timeout.
        if (isolateM1M3) begin
          state_d     = IDLE;
          iso_abort_d = 1'b1;
        end else if (data_tx) begin
          state_d = REQ_LO;
        end else if (expired) begin
          state_d       = ERR;
          timeout_err_d = 1'b1;
        end else begin
          state_d = REQ_HI;
        end
      end
      REQ_LO: begin
        if (isolateM1M3) begin
          state_d     = IDLE;
          iso_abort_d = 1'b1;
        end else if (!data_tx) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          txn_count_d = txn_count_q + CNT_W'(1);
        end else if (expired) begin
          state_d       = ERR;
          timeout_err_d = 1'b1;
        end else begin
          state_d = REQ_LO;
        end
      end
      ERR: begin
        // A simultaneous start is deliberately dropped here.
        if (clear_err) begin
          state_d       = IDLE;
          timeout_err_d = 1'b0;
        end else begin
          state_d = ERR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    data_ready_d = (state_d == REQ_HI);
    busy_d       = (state_d != IDLE);
    wait_en      = ((state_q == REQ_HI) || (state_q == REQ_LO)) && (state_d == state_q);
    wait_clr     = !wait_en;
  end

  // State and output registers.
  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      state_q       <= IDLE;
      data_ready_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      iso_abort_q   <= 1'b0;
      txn_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      data_ready_q  <= data_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      iso_abort_q   <= iso_abort_d;
      txn_count_q   <= txn_count_d;
    end
  end

  assign data_ready  = data_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign iso_abort   = iso_abort_q;
  assign txn_count   = txn_count_q;

endmodule
